// File: rtl/hazard_pipe_ctrl_if.sv
// Bundle of fetch-side inputs and MW-stage / hazard outputs for hazard_pipe_ctrl.
// The master side drives the instruction and controls; the slave side is the controller.
interface hazard_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  inst_f;
  logic             reg_wr;
  logic [1:0]       wb_sel;
  logic             br_taken;
  logic             reg_wr_mw;
  logic [1:0]       wb_sel_mw;
  logic [2:0]       funct3_mw;
  logic [6:0]       opcode_mw;
  logic [4:0]       rd_mw;
  logic             fwd_a;
  logic             fwd_b;
  logic             stall_f;
  logic             flush_f;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output inst_f, reg_wr, wb_sel, br_taken,
    input  reg_wr_mw, wb_sel_mw, funct3_mw, opcode_mw, rd_mw,
    input  fwd_a, fwd_b, stall_f, flush_f, bubble_cnt
  );

  modport slave (
    input  inst_f, reg_wr, wb_sel, br_taken,
    output reg_wr_mw, wb_sel_mw, funct3_mw, opcode_mw, rd_mw,
    output fwd_a, fwd_b, stall_f, flush_f, bubble_cnt
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// MW pipeline register with MW->EX forwarding, load-use stall and branch flush control.
// Bubbles zero the MW register; a saturating counter tracks how many were inserted.
module hazard_pipe_ctrl #(
  parameter int XLEN        = 32,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_pipe_if.slave bus
);
  localparam int MAX_DEPTH = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
  localparam int CW        = $clog2(MAX_DEPTH + 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [1:0] WB_LOAD  = 2'b10;

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             reg_wr_mw_q, reg_wr_mw_d;
  logic [1:0]       wb_sel_mw_q, wb_sel_mw_d;
  logic [2:0]       funct3_mw_q, funct3_mw_d;
  logic [6:0]       opcode_mw_q, opcode_mw_d;
  logic [4:0]       rd_mw_q, rd_mw_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic       stall_c, flush_c, bubble_c;
  logic       rs1_used, rs2_used, match_1, match_2, load_use;
  logic [4:0] rs1, rs2;
  logic [6:0] opcode_f;
  logic       unused_inst_bits;

  assign opcode_f         = bus.inst_f[6:0];
  assign rs1              = bus.inst_f[19:15];
  assign rs2              = bus.inst_f[24:20];
  assign unused_inst_bits = ^bus.inst_f[XLEN-1:25];

  assign rs1_used = !((opcode_f == OP_LUI) || (opcode_f == OP_AUIPC) || (opcode_f == OP_JAL));
  assign rs2_used = (opcode_f == OP_REG) || (opcode_f == OP_STORE) || (opcode_f == OP_BR);
  assign match_1  = reg_wr_mw_q && (rd_mw_q != 5'd0) && (rd_mw_q == rs1) && rs1_used;
  assign match_2  = reg_wr_mw_q && (rd_mw_q != 5'd0) && (rd_mw_q == rs2) && rs2_used;
  assign load_use = (match_1 || match_2) && (wb_sel_mw_q == WB_LOAD);

  // Next-state and per-cycle stall/flush/bubble decisions; br_taken outranks load-use.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    case (state_q)
      IDLE, STALL: begin
        if (bus.br_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_DEPTH - 1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (state_q == STALL) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end else if (load_use) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (bus.br_taken) begin
          if (FLUSH_DEPTH > 1) begin
            cnt_d = CW'(FLUSH_DEPTH - 1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    reg_wr_mw_d  = 1'b0;
    wb_sel_mw_d  = 2'b00;
    funct3_mw_d  = 3'd0;
    opcode_mw_d  = 7'd0;
    rd_mw_d      = 5'd0;
    bubble_cnt_d = bubble_cnt_q;
    if (!bubble_c) begin
      reg_wr_mw_d = bus.reg_wr;
      wb_sel_mw_d = bus.wb_sel;
      funct3_mw_d = bus.inst_f[14:12];
      opcode_mw_d = opcode_f;
      rd_mw_d     = bus.inst_f[11:7];
    end else if (bubble_cnt_q != {CNT_W{1'b1}}) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      reg_wr_mw_q  <= 1'b0;
      wb_sel_mw_q  <= 2'b00;
      funct3_mw_q  <= 3'd0;
      opcode_mw_q  <= 7'd0;
      rd_mw_q      <= 5'd0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_wr_mw_q  <= reg_wr_mw_d;
      wb_sel_mw_q  <= wb_sel_mw_d;
      funct3_mw_q  <= funct3_mw_d;
      opcode_mw_q  <= opcode_mw_d;
      rd_mw_q      <= rd_mw_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Forwarding is suppressed whenever the current instruction is being held or killed.
  assign bus.stall_f    = stall_c && !rst;
  assign bus.flush_f    = flush_c && !rst;
  assign bus.fwd_a      = match_1 && (wb_sel_mw_q != WB_LOAD) && !stall_c && !flush_c && !rst;
  assign bus.fwd_b      = match_2 && (wb_sel_mw_q != WB_LOAD) && !stall_c && !flush_c && !rst;
  assign bus.reg_wr_mw  = reg_wr_mw_q;
  assign bus.wb_sel_mw  = wb_sel_mw_q;
  assign bus.funct3_mw  = funct3_mw_q;
  assign bus.opcode_mw  = opcode_mw_q;
  assign bus.rd_mw      = rd_mw_q;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Scenario bench for hazard_pipe_ctrl: MW contents are scoreboarded, control outputs
// and bubble counts are checked inline by each scenario task.
module tb_hazard_pipe_ctrl;
  localparam int XLEN = 32;
  localparam int LL   = 2;
  localparam int FD   = 2;
  localparam int CW   = 3;

  localparam logic [31:0] ADDI_X1   = 32'h00500093;
  localparam logic [31:0] ADDI_X0   = 32'h00500013;
  localparam logic [31:0] ADD_X2    = 32'h00208133;
  localparam logic [31:0] ADD_X2_X0 = 32'h00200133;
  localparam logic [31:0] ADD_X3    = 32'h002081B3;
  localparam logic [31:0] LUI_X4    = 32'h00018237;
  localparam logic [31:0] LW_X5     = 32'h00002283;
  localparam logic [31:0] ADD_X6    = 32'h00528333;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [3:0]  ctl;

  hazard_pipe_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  hazard_pipe_ctrl #(.XLEN(XLEN), .LOAD_LAT(LL), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: each expected MW record is popped after the capture edge it belongs to.
  always @(negedge clk) begin : mw_monitor
    logic [17:0] exp_rec;
    logic [17:0] got_rec;
    if (exp_q.size() > 0) begin
      exp_rec = exp_q.pop_front();
      got_rec = {bus.reg_wr_mw, bus.wb_sel_mw, bus.funct3_mw, bus.opcode_mw, bus.rd_mw};
      checks++;
      if (got_rec !== exp_rec) begin
        errors++;
        $display("FAIL mw_capture t=%0t got=%h expected=%h", $time, got_rec, exp_rec);
      end else begin
        $display("mw_capture t=%0t ok rec=%h", $time, got_rec);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic cyc(input logic [31:0] inst, input logic rw, input logic [1:0] ws,
                     input logic br, input logic exp_bub);
    bus.inst_f   = inst;
    bus.reg_wr   = rw;
    bus.wb_sel   = ws;
    bus.br_taken = br;
    exp_q.push_back(exp_bub ? 18'd0 : {rw, ws, inst[14:12], inst[6:0], inst[11:7]});
    #1;
    ctl = {bus.stall_f, bus.flush_f, bus.fwd_a, bus.fwd_b};
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.inst_f   = '0;
    bus.reg_wr   = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.br_taken = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.inst_f   = $urandom;
      bus.reg_wr   = 1'($urandom);
      bus.wb_sel   = 2'($urandom);
      bus.br_taken = 1'($urandom);
      tick();
      checks++;
      if ({bus.reg_wr_mw, bus.wb_sel_mw, bus.funct3_mw, bus.opcode_mw, bus.rd_mw,
           bus.bubble_cnt, bus.stall_f, bus.flush_f} !== '0) begin
        errors++;
        $display("FAIL reset_state mw=%b%b%h%h%h cnt=%0d stall=%b flush=%b required all 0",
                 bus.reg_wr_mw, bus.wb_sel_mw, bus.funct3_mw, bus.opcode_mw, bus.rd_mw,
                 bus.bubble_cnt, bus.stall_f, bus.flush_f);
      end else $display("reset_state cycle %0d ok", i);
    end
    rst = 1'b0;
    exp_q.delete();
    cyc(ADDI_X1, 1'b1, 2'b01, 1'b0, 1'b0);
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL reset_first_ctl ctl=%b required=0000", ctl);
    end
    tick();
    checks++;
    if (bus.opcode_mw !== 7'b0010011 || bus.rd_mw !== 5'd1 || bus.reg_wr_mw !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_capture op=%b rd=%0d rw=%b required op=0010011 rd=1 rw=1",
               bus.opcode_mw, bus.rd_mw, bus.reg_wr_mw);
    end else $display("reset_first_capture ok");
  endtask

  task automatic test_forward();
    logic [3:0] exp_ctl [6] = '{4'b0000, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] insts [6] = '{ADDI_X1, ADD_X2, ADD_X3, LUI_X4, ADDI_X0, ADD_X2_X0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(insts[i], 1'b1, (i == 3) ? 2'b00 : 2'b01, 1'b0, 1'b0);
      checks++;
      if (ctl !== exp_ctl[i]) begin
        errors++;
        $display("FAIL fwd_step%0d inst=%h stall/flush/fa/fb=%b required=%b",
                 i, insts[i], ctl, exp_ctl[i]);
      end else $display("fwd_step%0d inst=%h ctl=%b ok", i, insts[i], ctl);
      tick();
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    cyc(LW_X5, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      cyc(ADD_X6, 1'b1, 2'b01, 1'b0, (i < LL) ? 1'b1 : 1'b0);
      checks++;
      if (ctl !== ((i < LL) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL load_use_c%0d stall/flush/fa/fb=%b required=%b",
                 i, ctl, (i < LL) ? 4'b1000 : 4'b0000);
      end else $display("load_use_c%0d ctl=%b ok", i, ctl);
      tick();
    end
    checks++;
    if (bus.bubble_cnt !== 3'd2) begin
      errors++;
      $display("FAIL load_use_count bubble_cnt=%0d required=2", bus.bubble_cnt);
    end
  endtask

  task automatic test_flush();
    logic       brs  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       bubs [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(bubs[i] ? NOP : ADDI_X1, 1'b1, 2'b01, brs[i], bubs[i]);
      checks++;
      if (ctl !== (bubs[i] ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL flush_c%0d stall/flush/fa/fb=%b required=%b",
                 i, ctl, bubs[i] ? 4'b0100 : 4'b0000);
      end else $display("flush_c%0d br=%b ctl=%b ok", i, brs[i], ctl);
      tick();
    end
    checks++;
    if (bus.bubble_cnt !== 3'd5) begin
      errors++;
      $display("FAIL flush_count bubble_cnt=%0d required=5", bus.bubble_cnt);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    cyc(LW_X5, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    cyc(ADD_X6, 1'b1, 2'b01, 1'b1, 1'b1);
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL collide_c0 stall/flush/fa/fb=%b required=0100", ctl);
    end else $display("collide_c0 ctl=%b ok", ctl);
    tick();
    cyc(ADD_X6, 1'b1, 2'b01, 1'b0, 1'b1);
    checks++;
    if (ctl !== 4'b0100) begin
      errors++;
      $display("FAIL collide_c1 stall/flush/fa/fb=%b required=0100", ctl);
    end else $display("collide_c1 ctl=%b ok", ctl);
    tick();
    cyc(ADD_X6, 1'b1, 2'b01, 1'b0, 1'b0);
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL collide_c2 stall/flush/fa/fb=%b required=0000", ctl);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    cyc(LW_X5, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    cyc(ADD_X6, 1'b1, 2'b01, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.reg_wr_mw, bus.wb_sel_mw, bus.rd_mw, bus.opcode_mw, bus.bubble_cnt,
         bus.stall_f} !== '0) begin
      errors++;
      $display("FAIL rst_mid_stall rw=%b wb=%b rd=%0d op=%b cnt=%0d stall=%b required all 0",
               bus.reg_wr_mw, bus.wb_sel_mw, bus.rd_mw, bus.opcode_mw, bus.bubble_cnt,
               bus.stall_f);
    end else $display("rst_mid_stall ok");
    rst = 1'b0;
    cyc(ADD_X6, 1'b1, 2'b01, 1'b0, 1'b0);
    checks++;
    if (ctl !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_stall_after stall/flush/fa/fb=%b required=0000", ctl);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(NOP, 1'b1, 2'b01, 1'b1, 1'b1);
      tick();
      exp_cnt = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      checks++;
      if (bus.bubble_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL sat_b%0d bubble_cnt=%0d required=%0d", i, bus.bubble_cnt, exp_cnt);
      end else $display("sat_b%0d bubble_cnt=%0d ok", i, bus.bubble_cnt);
    end
  endtask

  initial begin
    bus.inst_f   = '0;
    bus.reg_wr   = 1'b0;
    bus.wb_sel   = 2'b00;
    bus.br_taken = 1'b0;
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_flush();
    test_collision();
    test_reset_mid_stall();
    test_saturation();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_pipe_ctrl.md
# hazard_pipe_ctrl

Parametrised pipeline-register and hazard controller between the fetch/decode-execute stage and the memory-writeback (MW) stage of the RV32I pipeline. Each cycle it registers the writeback controls (reg_wr, wb_sel) and the decoded instruction fields (funct3, opcode, rd) into the MW stage. It also detects MW-to-execute forwarding and load-use hazards, drives fetch stall/flush with configurable bubble depth, and counts inserted bubbles.

## Interface
Parameters:
- XLEN, 32, instruction/datapath width (instruction fields fixed at RV32 bit positions)
- LOAD_LAT, 1, stall cycles per load-use hazard (>=1)
- FLUSH_DEPTH, 1, fetch slots killed per taken branch/jump (>=1)
- CNT_W, 16, width of bubble performance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst_f  in  XLEN  instruction currently in fetch/execute
- reg_wr  in  1  register-file write enable for inst_f
- wb_sel  in  2  writeback source for inst_f: 00 PC+4, 01 ALU, 10 load data, 11 CSR
- br_taken  in  1  taken branch/jump resolved this cycle
- reg_wr_mw  out  1  registered reg_wr
- wb_sel_mw  out  2  registered wb_sel
- funct3_mw  out  3  registered inst_f[14:12]
- opcode_mw  out  7  registered inst_f[6:0]
- rd_mw  out  5  registered inst_f[11:7]
- fwd_a  out  1  forward MW result to operand A (rs1)
- fwd_b  out  1  forward MW result to operand B (rs2)
- stall_f  out  1  hold PC and inst_f this cycle
- flush_f  out  1  kill inst_f this cycle
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted into MW

## Operation
- Source fields: rs1=inst_f[19:15], rs2=inst_f[24:20].
- rs1 used unless opcode is 0110111, 0010111, or 1101111. rs2 used only for opcodes 0110011, 0100011, 1100011.
- match_x: reg_wr_mw=1 and rd_mw!=0 and rd_mw==rsX and rsX used.
- Forwarding (combinational): fwd_a=match_1 and wb_sel_mw!=10; fwd_b=match_2 and wb_sel_mw!=10. Both are forced 0 when stall_f or flush_f is 1.
- Load-use hazard: (match_1 or match_2) and wb_sel_mw==10.
- Bubble: the MW register loads all zeros (reg_wr_mw=0, wb_sel_mw=00, funct3/opcode/rd=0). Otherwise it loads the inst_f fields plus reg_wr/wb_sel.
- FSM states:
  - IDLE:
    - br_taken: flush_f=1 and bubble; go to FLUSH with cnt=FLUSH_DEPTH-1 if FLUSH_DEPTH>1, else stay.
    - Else load-use: stall_f=1 and bubble; go to STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1, else stay.
    - Else: normal capture.
  - STALL:
    - stall_f=1 and bubble; cnt decrements; return to IDLE when cnt==1.
    - br_taken: abort the stall and behave as br_taken in IDLE.
  - FLUSH:
    - flush_f=1 and bubble; cnt decrements; return to IDLE when cnt==1.
    - br_taken: reload cnt=FLUSH_DEPTH-1 and stay, or go to IDLE if FLUSH_DEPTH==1.
    - Load-use detection is ignored.
- Priority: rst > br_taken > load-use > capture.
- bubble_cnt increments on every bubble-load edge and saturates at 2^CNT_W-1.
- Counter widths: $clog2(max(LOAD_LAT,FLUSH_DEPTH)+1).

## Timing
- Capture latency: 1 cycle (inst_f at edge t appears on *_mw after t).
- stall_f, flush_f, fwd_a, fwd_b are combinational in the detecting cycle; there is no registered delay.
- A load-use hazard gives exactly LOAD_LAT stall_f cycles. A taken branch gives exactly FLUSH_DEPTH flush_f cycles.
- After a stall ends, the held inst_f is captured on the first IDLE edge. Its hazard is re-evaluated against the bubble (rd_mw=0), so no stall repeats.
- Reset values: reg_wr_mw=0, wb_sel_mw=00, funct3_mw=0, opcode_mw=0, rd_mw=0, bubble_cnt=0, FSM=IDLE, cnt=0. Consequently stall_f, flush_f, fwd_a, fwd_b evaluate to 0.
- rst asserted mid-STALL or mid-FLUSH returns everything to reset values at that edge. stall_f/flush_f are 0 in the first cycle after reset.

## Test plan
- Reset: drive rst=1 with random inputs for 2 cycles -> all *_mw=0, bubble_cnt=0, stall_f=flush_f=0. Release; inst_f=0x00500093 (addi x1,x0,5), reg_wr=1, wb_sel=01 -> next cycle opcode_mw=0010011, rd_mw=1, reg_wr_mw=1.
- Forward: MW holds addi x1 with wb_sel_mw=01; inst_f=0x00208133 (add x2,x1,x2) -> fwd_a=1, fwd_b=0, stall_f=0. Same case with rd_mw=0 -> fwd_a=0.
- Load-use, LOAD_LAT=2: MW holds lw x5 (wb_sel_mw=10); inst_f=0x00528333 (add x6,x5,x5) -> stall_f=1 for exactly 2 cycles, two bubbles, bubble_cnt+=2, fwd_a=fwd_b=0. The add is captured on the 3rd edge.
- Flush, FLUSH_DEPTH=2: br_taken pulse -> flush_f=1 for 2 cycles and MW shows zeros twice. A second br_taken in the 2nd flush cycle extends the flush by 1 further cycle.
- Collision: load-use and br_taken in the same cycle -> flush_f=1, stall_f=0, FSM enters FLUSH. Reset asserted mid-STALL -> IDLE and zeros next cycle.
- Saturation with CNT_W=3: insert 10 bubbles -> bubble_cnt stops at 7.
